// File: rtl/mem_ctrl_if.sv
// CPU data-port bundle for mem_ctrl.
// Request level/address/data in, busy/ready/read data out.
interface mem_ctrl_if;
    logic [15:0] addr_bus;
    logic [15:0] data_in;
    logic        ram_read;
    logic        ram_write;
    logic [15:0] mem_bus;
    logic        mem_busy;
    logic        mem_ready;

    modport master (
        output addr_bus, data_in, ram_read, ram_write,
        input  mem_bus, mem_busy, mem_ready
    );

    modport slave (
        input  addr_bus, data_in, ram_read, ram_write,
        output mem_bus, mem_busy, mem_ready
    );
endinterface

// File: rtl/mem_ctrl.sv
// Data-memory responder: async SRAM with wait states
// plus one memory-mapped I/O word.
module mem_ctrl #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    mem_ctrl_if.slave   bus,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_dout,
    input  logic [15:0] sram_din,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [15:0] io_out,
    input  logic [15:0] io_in
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);
    localparam logic       ONE_WS   = (WAIT_STATES == 1);

    state_t     state;
    logic [3:0] cnt;
    logic       wr_q;

    // Request FSM; every output is a register set on the transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            wr_q          <= 1'b0;
            sram_addr     <= '0;
            sram_dout     <= '0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            io_out        <= '0;
            bus.mem_bus   <= '0;
            bus.mem_busy  <= 1'b0;
            bus.mem_ready <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.ram_write || bus.ram_read) begin
                        if (bus.addr_bus == IO_ADDR) begin
                            if (bus.ram_write)
                                io_out <= bus.data_in;
                            else
                                bus.mem_bus <= io_in;
                            bus.mem_ready <= 1'b1;
                            state         <= DONE;
                        end else begin
                            // Write wins when both levels are high.
                            wr_q         <= bus.ram_write;
                            sram_addr    <= bus.addr_bus;
                            sram_dout    <= bus.data_in;
                            cnt          <= CNT_INIT;
                            bus.mem_busy <= 1'b1;
                            sram_ce_n    <= 1'b0;
                            sram_oe_n    <= bus.ram_write;
                            // First cycle is address setup unless
                            // it is the only cycle.
                            sram_we_n    <= ~(bus.ram_write & ONE_WS);
                            state        <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!wr_q)
                            bus.mem_bus <= sram_din;
                        bus.mem_busy  <= 1'b0;
                        bus.mem_ready <= 1'b1;
                        sram_ce_n     <= 1'b1;
                        sram_oe_n     <= 1'b1;
                        sram_we_n     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (wr_q)
                            sram_we_n <= 1'b0;
                    end
                end
                DONE: begin
                    bus.mem_ready <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: one instance with two
// wait states, one with a single wait state.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mem_ctrl_if bus0 ();
    mem_ctrl_if bus1 ();

    logic [15:0] sram_addr0, sram_dout0, sram_din0, io_out0;
    logic        ce_n0, oe_n0, we_n0;
    logic [15:0] sram_addr1, sram_dout1, sram_din1, io_out1;
    logic        ce_n1, oe_n1, we_n1;
    logic [15:0] io_in;

    mem_ctrl #(.WAIT_STATES(2), .IO_ADDR(16'hFFFF)) u0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0.slave),
        .sram_addr (sram_addr0),
        .sram_dout (sram_dout0),
        .sram_din  (sram_din0),
        .sram_ce_n (ce_n0),
        .sram_oe_n (oe_n0),
        .sram_we_n (we_n0),
        .io_out    (io_out0),
        .io_in     (io_in)
    );

    mem_ctrl #(.WAIT_STATES(1), .IO_ADDR(16'hFFFF)) u1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1.slave),
        .sram_addr (sram_addr1),
        .sram_dout (sram_dout1),
        .sram_din  (sram_din1),
        .sram_ce_n (ce_n1),
        .sram_oe_n (oe_n1),
        .sram_we_n (we_n1),
        .io_out    (io_out1),
        .io_in     (io_in)
    );

    // SRAM model for u0: 256 words, address low byte.
    logic [15:0] mem0 [0:255];
    assign sram_din0 = mem0[sram_addr0[7:0]];
    always @(posedge clk)
        if (!ce_n0 && !we_n0)
            mem0[sram_addr0[7:0]] <= sram_dout0;

    // ROM-like pattern for u1 reads, write capture log.
    assign sram_din1 = sram_addr1 ^ 16'hA5A5;
    logic [15:0] wr_a1 = '0;
    logic [15:0] wr_d1 = '0;
    always @(posedge clk)
        if (!ce_n1 && !we_n1) begin
            wr_a1 <= sram_addr1;
            wr_d1 <= sram_dout1;
        end

    // Event counters sampled at each rising edge.
    int we_lo0 = 0;
    int strb0  = 0;
    int rdy0   = 0;
    int rdy1   = 0;
    always @(posedge clk) begin
        if (!we_n0) we_lo0 <= we_lo0 + 1;
        if (!ce_n0 || !oe_n0 || !we_n0) strb0 <= strb0 + 1;
        if (bus0.mem_ready) rdy0 <= rdy0 + 1;
        if (bus1.mem_ready) rdy1 <= rdy1 + 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    int base;

    initial begin
        rst = 1'b0;
        io_in = '0;
        bus0.addr_bus = '0; bus0.data_in = '0;
        bus0.ram_read = 1'b0; bus0.ram_write = 1'b0;
        bus1.addr_bus = '0; bus1.data_in = '0;
        bus1.ram_read = 1'b0; bus1.ram_write = 1'b0;
        repeat (2) nxt();

        chk("rst_busy", bus0.mem_busy, 0);
        chk("rst_ready", bus0.mem_ready, 0);
        chk("rst_strobes", {ce_n0, oe_n0, we_n0}, 3'b111);
        chk("rst_mem_bus", bus0.mem_bus, 0);
        chk("rst_io_out", io_out0, 0);
        chk("rst_sram_addr", sram_addr0, 0);
        chk("rst_sram_dout", sram_dout0, 0);
        rst = 1'b1;
        nxt();
        chk("rel_idle", {bus0.mem_busy, bus0.mem_ready}, 2'b00);

        // SRAM write BEEF -> 0123
        base = we_lo0;
        bus0.addr_bus = 16'h0123;
        bus0.data_in = 16'hBEEF;
        bus0.ram_write = 1'b1;
        nxt();
        chk("wr_c1_busy", bus0.mem_busy, 1);
        chk("wr_c1_ce", ce_n0, 0);
        chk("wr_c1_we_setup", we_n0, 1);
        chk("wr_c1_addr", sram_addr0, 16'h0123);
        chk("wr_c1_dout", sram_dout0, 16'hBEEF);
        nxt();
        chk("wr_c2_we", we_n0, 0);
        chk("wr_c2_ready", bus0.mem_ready, 0);
        nxt();
        chk("wr_done_ready", bus0.mem_ready, 1);
        chk("wr_done_busy", bus0.mem_busy, 0);
        chk("wr_done_strb", {ce_n0, oe_n0, we_n0}, 3'b111);
        bus0.ram_write = 1'b0;
        nxt();
        chk("wr_idle_ready", bus0.mem_ready, 0);
        chk("wr_we_cycles", we_lo0 - base, 1);
        chk("wr_sram_word", mem0[8'h23], 16'hBEEF);

        // SRAM read back 0123
        bus0.ram_read = 1'b1;
        nxt();
        chk("rd_c1_oe", {ce_n0, oe_n0, we_n0}, 3'b001);
        nxt();
        chk("rd_c2_ready", bus0.mem_ready, 0);
        nxt();
        chk("rd_done_ready", bus0.mem_ready, 1);
        chk("rd_data", bus0.mem_bus, 16'hBEEF);
        bus0.ram_read = 1'b0;
        nxt();

        // I/O write and read
        base = strb0;
        bus0.addr_bus = 16'hFFFF;
        bus0.data_in = 16'h00A5;
        bus0.ram_write = 1'b1;
        nxt();
        chk("io_wr_ready", bus0.mem_ready, 1);
        chk("io_wr_out", io_out0, 16'h00A5);
        chk("io_wr_busy", bus0.mem_busy, 0);
        bus0.ram_write = 1'b0;
        nxt();
        chk("io_wr_ready_off", bus0.mem_ready, 0);
        io_in = 16'h1234;
        bus0.ram_read = 1'b1;
        nxt();
        chk("io_rd_ready", bus0.mem_ready, 1);
        chk("io_rd_data", bus0.mem_bus, 16'h1234);
        bus0.ram_read = 1'b0;
        nxt();
        chk("io_no_strobes", strb0 - base, 0);

        // Read and write together: write wins
        bus0.addr_bus = 16'h0010;
        bus0.data_in = 16'h5555;
        bus0.ram_read = 1'b1;
        bus0.ram_write = 1'b1;
        nxt();
        chk("both_oe_off", oe_n0, 1);
        nxt();
        chk("both_we_on", we_n0, 0);
        nxt();
        chk("both_ready", bus0.mem_ready, 1);
        chk("both_mem_bus", bus0.mem_bus, 16'h1234);
        chk("both_sram_word", mem0[8'h10], 16'h5555);
        bus0.ram_read = 1'b0;
        bus0.ram_write = 1'b0;
        nxt();

        // Request dropped mid-access, address changed
        base = rdy0;
        bus0.addr_bus = 16'h0123;
        bus0.ram_read = 1'b1;
        nxt();
        bus0.ram_read = 1'b0;
        bus0.addr_bus = 16'h0200;
        nxt();
        chk("drop_addr", sram_addr0, 16'h0123);
        chk("drop_busy", bus0.mem_busy, 1);
        nxt();
        chk("drop_ready", bus0.mem_ready, 1);
        chk("drop_data", bus0.mem_bus, 16'hBEEF);
        repeat (3) nxt();
        chk("drop_one_pulse", rdy0 - base, 1);

        // Back-to-back on the single-wait-state instance
        base = rdy1;
        bus1.addr_bus = 16'h0040;
        bus1.ram_read = 1'b1;
        nxt();
        chk("b2b_r1_busy", bus1.mem_busy, 1);
        chk("b2b_r1_oe", oe_n1, 0);
        nxt();
        chk("b2b_r1_ready", bus1.mem_ready, 1);
        chk("b2b_r1_data", bus1.mem_bus, 16'hA5E5);
        bus1.addr_bus = 16'h1234;
        nxt();
        chk("b2b_gap1", {bus1.mem_busy, bus1.mem_ready}, 2'b00);
        nxt();
        chk("b2b_r2_busy", bus1.mem_busy, 1);
        nxt();
        chk("b2b_r2_ready", bus1.mem_ready, 1);
        chk("b2b_r2_data", bus1.mem_bus, 16'hB791);
        bus1.ram_read = 1'b0;
        bus1.ram_write = 1'b1;
        bus1.addr_bus = 16'h0050;
        bus1.data_in = 16'hCAFE;
        nxt();
        chk("b2b_gap2", {bus1.mem_busy, bus1.mem_ready}, 2'b00);
        nxt();
        chk("b2b_w_we", we_n1, 0);
        chk("b2b_w_busy", bus1.mem_busy, 1);
        nxt();
        chk("b2b_w_ready", bus1.mem_ready, 1);
        chk("b2b_w_keep_bus", bus1.mem_bus, 16'hB791);
        chk("b2b_w_addr", wr_a1, 16'h0050);
        chk("b2b_w_data", wr_d1, 16'hCAFE);
        bus1.ram_write = 1'b0;
        repeat (3) nxt();
        chk("b2b_pulses", rdy1 - base, 3);

        // Asynchronous reset in the middle of a write
        base = rdy0;
        bus0.addr_bus = 16'h0030;
        bus0.data_in = 16'h7777;
        bus0.ram_write = 1'b1;
        nxt();
        chk("ar_busy_pre", bus0.mem_busy, 1);
        rst = 1'b0;
        #1;
        chk("ar_busy", bus0.mem_busy, 0);
        chk("ar_strobes", {ce_n0, oe_n0, we_n0}, 3'b111);
        chk("ar_sram_addr", sram_addr0, 0);
        chk("ar_mem_bus", bus0.mem_bus, 0);
        chk("ar_io_out", io_out0, 0);
        bus0.ram_write = 1'b0;
        nxt();
        rst = 1'b1;
        repeat (4) nxt();
        chk("ar_post_idle", {bus0.mem_busy, bus0.mem_ready}, 2'b00);
        chk("ar_post_strb", {ce_n0, oe_n0, we_n0}, 3'b111);
        chk("ar_no_pulse", rdy0 - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Data-memory responder for the CPU's load/store port: accepts `ram_read`/`ram_write` requests with a 16-bit address and write data, drives an external asynchronous 16-bit SRAM with a programmable number of wait states, and answers with `mem_busy`/`mem_ready` plus read data. It sits between the CPU data port and board SRAM pins. A single memory-mapped I/O word, used for board outputs and inputs, is served without touching SRAM.

## Interface
- `WAIT_STATES`, 2, SRAM access cycles per transfer; legal range 1..15.
- `IO_ADDR`, 16'hFFFF, address of the I/O word.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `addr_bus`  in  16  request address, held stable by the CPU while a request is asserted.
- `data_in`  in  16  write data, held stable with `ram_write`.
- `ram_read`  in  1  read request level.
- `ram_write`  in  1  write request level.
- `mem_bus`  out  16  read data register.
- `mem_busy`  out  1  high while an access is in progress.
- `mem_ready`  out  1  one-cycle completion pulse.
- `sram_addr`  out  16  SRAM address.
- `sram_dout`  out  16  SRAM write data.
- `sram_din`  in  16  SRAM read data.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  SRAM strobes, active-low.
- `io_out`  out  16  I/O output register.
- `io_in`  in  16  I/O input word.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Sample the request at each edge.
  - If `ram_write`=1, or `ram_read`=1, and `addr_bus`≠`IO_ADDR`: latch address, data and direction. Write takes priority when both are high. Load counter with `WAIT_STATES`-1 and go to ACCESS.
  - If the address equals `IO_ADDR`:
    - write: `io_out`←`data_in`.
    - read: `mem_bus`←`io_in`.
    - Go directly to DONE.
- ACCESS:
  - `mem_busy`=1, `sram_ce_n`=0, `sram_addr`=latched address.
  - Read: `sram_oe_n`=0 for all ACCESS cycles.
  - Write: `sram_dout`=latched data on all cycles; `sram_we_n`=0 on all ACCESS cycles except the first (address setup). With `WAIT_STATES`=1, `sram_we_n` is still asserted for that single cycle.
  - Counter decrements each edge. At count 0, go to DONE; on a read, load `mem_bus`←`sram_din` on that same edge.
- DONE:
  - `mem_ready`=1, `mem_busy`=0, all strobes high.
  - Unconditionally return to IDLE.
  - The request present during DONE is the completed one and is not re-sampled.
- `mem_bus` holds its value until the next read completes; writes leave it unchanged.
- Request deasserted during ACCESS: the access still completes and `mem_ready` still pulses. Latched values are used, so mid-access changes to `addr_bus`/`data_in` are ignored.
- Reset values:
  - state IDLE; `mem_busy`=0, `mem_ready`=0.
  - `mem_bus`=0, `io_out`=0, `sram_addr`=0, `sram_dout`=0.
  - `sram_ce_n`/`sram_oe_n`/`sram_we_n`=1.
- Reset asserted mid-access: all outputs take reset values immediately (asynchronously), with no `mem_ready` pulse. An aborted write may leave the SRAM word undefined.

## Timing
- All outputs are registered, or decoded from state only; no combinational path from CPU inputs to outputs.
- SRAM request accepted at edge k:
  - ACCESS occupies cycles k+1 .. k+`WAIT_STATES`.
  - DONE (`mem_ready`=1) in cycle k+`WAIT_STATES`+1.
  - Earliest next acceptance at edge k+`WAIT_STATES`+2.
  - With the default of 2, the request-to-ready latency is 3 cycles.
- I/O request accepted at edge k: DONE in cycle k+1, next acceptance at edge k+2.
- `mem_bus` is valid in the DONE cycle and stays valid afterwards.
- Back-to-back requests: a new request may be high in the IDLE cycle immediately following DONE.

## Test plan
- Reset: with `rst`=0 mid-ACCESS, outputs go idle within the same cycle. After release, `mem_busy`=0, `mem_ready`=0 and all strobes are high.
- SRAM write then read, `WAIT_STATES`=2:
  - Write 16'hBEEF to 16'h0123: `sram_we_n` is low for exactly 1 cycle, `mem_ready` pulses 3 cycles after acceptance.
  - Read back from a bench SRAM model: `mem_bus`=16'hBEEF in the DONE cycle.
- I/O: write 16'h00A5 to 16'hFFFF: `io_out`=16'h00A5 one cycle later, `mem_ready` at k+1, SRAM strobes never asserted. With `io_in`=16'h1234, a read returns 16'h1234.
- Simultaneous `ram_read`=`ram_write`=1 at 16'h0010 with data 16'h5555: a write occurs, and `mem_bus` keeps its previous value.
- Request dropped during ACCESS and `addr_bus` changed: the SRAM address stays at the latched value, and exactly one `mem_ready` pulse is issued.
- Back-to-back read, read, write with `WAIT_STATES`=1: each completes in 2 cycles, with no missed or duplicated `mem_ready` pulse.
